// File: rtl/bist_pkg.sv
// Shared types and constants for the s386 BIST controller and its shift-register cells.
package bist_pkg;

  localparam int CUT_W = 7;

  // Feedback taps for x^7+x^6+1, shared by the pattern generator and the compactor.
  localparam logic [CUT_W-1:0] FB_TAPS = 7'h60;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    CHECK,
    DONE
  } bist_state_e;

  typedef enum logic {
    MODE_LFSR,
    MODE_MISR
  } lfsr_mode_e;

  function automatic logic [CUT_W-1:0] lfsr_step(input logic [CUT_W-1:0] cur);
    return {cur[CUT_W-2:0], ^(cur & FB_TAPS)};
  endfunction

endpackage

// File: rtl/bist_ctrl_s386_if.sv
// Test-side connection between the BIST controller and the s386 core wrapper.
interface bist_ctrl_s386_if;
  import bist_pkg::*;

  logic             start;
  logic             abort;
  logic [CUT_W-1:0] cut_out;
  logic [CUT_W-1:0] cut_in;
  logic             cut_ce;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CUT_W-1:0] signature;

  modport master (
    output start, abort, cut_out,
    input  cut_in, cut_ce, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, cut_out,
    output cut_in, cut_ce, busy, done, pass, signature
  );

endinterface

// File: rtl/bist_lfsr7.sv
// 7-bit shift register with x^7+x^6+1 feedback, usable as a pattern LFSR or as a MISR.
module bist_lfsr7
  import bist_pkg::*;
#(
  parameter lfsr_mode_e       MODE = MODE_LFSR,
  parameter logic [CUT_W-1:0] SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             load,
  input  logic [CUT_W-1:0] din,
  output logic [CUT_W-1:0] q
);

  logic [CUT_W-1:0] q_q;
  logic [CUT_W-1:0] q_d;

  // Load wins over shifting so a new test always starts from the seed.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = SEED;
    end else if (ce) begin
      q_d = lfsr_step(q_q) ^ ((MODE == MODE_MISR) ? din : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bist_ctrl_s386.sv
// BIST sequencer for the s386 core: init vector, LFSR patterns with MISR compaction, signature check.
module bist_ctrl_s386
  import bist_pkg::*;
#(
  parameter int               PAT_COUNT   = 127,
  parameter int               INIT_CYCLES = 8,
  parameter logic [CUT_W-1:0] INIT_VEC    = 7'h00,
  parameter logic [CUT_W-1:0] LFSR_SEED   = 7'h01,
  parameter logic [CUT_W-1:0] GOLDEN_SIG  = 7'h00
) (
  input logic              CK,
  input logic              RST,
  bist_ctrl_s386_if.slave  bus
);

  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [7:0] PAT_LAST  = 8'(PAT_COUNT - 1);

  bist_state_e      state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic [CUT_W-1:0] sig_q, sig_d;
  logic             seq_load;
  logic             seq_ce;
  logic             busy_w;
  logic [CUT_W-1:0] lfsr_q;
  logic [CUT_W-1:0] misr_q;

  bist_lfsr7 #(
    .MODE (MODE_LFSR),
    .SEED (LFSR_SEED)
  ) u_pattern (
    .clk  (CK),
    .rst  (RST),
    .ce   (seq_ce),
    .load (seq_load),
    .din  ('0),
    .q    (lfsr_q)
  );

  bist_lfsr7 #(
    .MODE (MODE_MISR),
    .SEED ('0)
  ) u_compactor (
    .clk  (CK),
    .rst  (RST),
    .ce   (seq_ce),
    .load (seq_load),
    .din  (bus.cut_out),
    .q    (misr_q)
  );

  assign busy_w = (state_q == INIT) || (state_q == RUN) || (state_q == CHECK);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    sig_d    = sig_q;
    seq_load = 1'b0;
    seq_ce   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = INIT;
          cnt_d    = '0;
          seq_load = 1'b1;
        end
      end
      INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RUN: begin
        seq_ce = 1'b1;
        if (cnt_q == PAT_LAST) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CHECK: begin
        sig_d   = misr_q;
        pass_d  = (misr_q == GOLDEN_SIG);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort reports the partial signature but never a pass.
    if (busy_w && bus.abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
      sig_d   = misr_q;
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  assign bus.cut_in    = (state_q == RUN) ? lfsr_q : INIT_VEC;
  assign bus.cut_ce    = (state_q == INIT) || (state_q == RUN);
  assign bus.busy      = busy_w;
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;

endmodule
